// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0 = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in ID_EX.
// Ports: id_rs1/id_rs2 (ID sources), idex_rd/idex_memread (ID_EX load),
//        load_use (1 = ID consumes the register the load is still producing).
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 idex_memread,
  output logic                 load_use
);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use = idex_memread & (idex_rd != X0) &
                    ((idex_rd == id_rs1) | (idex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Ports: clk/reset (sync, active-high); ID/ID_EX/EX_MEM hazard inputs;
//        dmem_req/dmem_ready handshake; per-stage enables and flushes;
//        pc_sel (branch target select); mem_err (sticky timeout);
//        stall_cnt/flush_cnt performance counters.
// Outputs are combinational from state and inputs.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] idex_rd,
  input  logic                 idex_memread,
  input  logic                 exmem_branch,
  input  logic                 exmem_zero,
  input  logic                 exmem_memread,
  input  logic                 exmem_memwrite,
  input  logic                 dmem_ready,
  output logic                 dmem_req,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 idex_en,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 exmem_flush,
  output logic                 pc_sel,
  output logic                 mem_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  state_t            state;
  state_t            state_next;
  logic              load_use;
  logic              mem_access;
  logic              branch_taken;
  logic              frozen;
  logic              stall_ev;
  logic              flush_ev;
  logic              wait_inc;
  logic              wait_clr;
  logic [WAIT_W-1:0] wait_cnt;

  hazard_detect u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .idex_rd      (idex_rd),
    .idex_memread (idex_memread),
    .load_use     (load_use)
  );

  assign mem_access   = exmem_memread | exmem_memwrite;
  assign branch_taken = exmem_branch & exmem_zero;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Next state, output muxing and event strobes; priority: mem wait > branch > load-use
  always_comb begin
    state_next  = state;
    dmem_req    = 1'b0;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_sel      = 1'b0;
    frozen      = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    wait_inc    = 1'b0;
    wait_clr    = 1'b0;

    if (reset) begin
      state_next  = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      if (state == MEM_WAIT) begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_next = RUN;
        end else begin
          frozen   = 1'b1;
          wait_inc = 1'b1;
        end
      end else if (mem_access) begin
        dmem_req = 1'b1;
        if (!dmem_ready) begin
          frozen     = 1'b1;
          wait_clr   = 1'b1;
          state_next = MEM_WAIT;
        end
      end

      if (frozen) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        stall_ev = 1'b1;
      end else if (branch_taken) begin
        pc_sel      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_ev    = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        stall_ev   = 1'b1;
      end
    end
  end

  // Performance counters, wrap naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_ev) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Wait-cycle counter and sticky timeout; mem_err sets on the edge the count reaches the limit
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      if (wait_clr) begin
        wait_cnt <= '0;
      end else if (wait_inc && (wait_cnt < WAIT_W'(MEM_WAIT_MAX))) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (wait_inc && (32'(wait_cnt) + 32'd1 >= 32'(MEM_WAIT_MAX))) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

  localparam int unsigned MAXW = 4;
  localparam int unsigned CW   = 8;

  // Observed vector order: dmem_req, pc/ifid/idex/exmem/memwb en, ifid/idex/exmem flush, pc_sel
  localparam logic [9:0] V_RESET  = 10'b0_00000_111_0;
  localparam logic [9:0] V_NORM   = 10'b0_11111_000_0;
  localparam logic [9:0] V_FROZEN = 10'b1_00000_000_0;
  localparam logic [9:0] V_LU     = 10'b0_00111_010_0;
  localparam logic [9:0] V_BR     = 10'b0_11111_111_1;
  localparam logic [9:0] V_REL    = 10'b1_11111_000_0;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, idex_rd;
  logic          idex_memread, exmem_branch, exmem_zero;
  logic          exmem_memread, exmem_memwrite, dmem_ready;
  logic          dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic          ifid_flush, idex_flush, exmem_flush, pc_sel, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [9:0]    obs;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_waiting;
  int m_wait_cycles;
  bit m_err;
  int m_stall;
  int m_flush;

  pipeline_ctrl #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .idex_rd        (idex_rd),
    .idex_memread   (idex_memread),
    .exmem_branch   (exmem_branch),
    .exmem_zero     (exmem_zero),
    .exmem_memread  (exmem_memread),
    .exmem_memwrite (exmem_memwrite),
    .dmem_ready     (dmem_ready),
    .dmem_req       (dmem_req),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .idex_en        (idex_en),
    .exmem_en       (exmem_en),
    .memwb_en       (memwb_en),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_flush    (exmem_flush),
    .pc_sel         (pc_sel),
    .mem_err        (mem_err),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign obs = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, pc_sel};

  always #5 clk = ~clk;

  function automatic bit m_load_use();
    return idex_memread && (idex_rd != 0) && (idex_rd == id_rs1 || idex_rd == id_rs2);
  endfunction

  function automatic bit m_frozen();
    bit mem = exmem_memread || exmem_memwrite;
    return !dmem_ready && (m_waiting || mem);
  endfunction

  // Expected combinational outputs for the current inputs and model state
  function automatic logic [9:0] exp_vec();
    bit req = m_waiting || exmem_memread || exmem_memwrite;
    if (reset)                          return V_RESET;
    if (m_frozen())                     return V_FROZEN;
    if (exmem_branch && exmem_zero)     return V_BR | {req, 9'b0};
    if (m_load_use())                   return V_LU | {req, 9'b0};
    return V_NORM | {req, 9'b0};
  endfunction

  // Advance the model by one clock using the inputs held at the edge
  task automatic model_edge();
    if (reset) begin
      m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_frozen())                          m_stall = (m_stall + 1) % (1 << CW);
      else if (exmem_branch && exmem_zero)     m_flush = (m_flush + 1) % (1 << CW);
      else if (m_load_use())                   m_stall = (m_stall + 1) % (1 << CW);
      if (m_waiting) begin
        if (dmem_ready) m_waiting = 0;
        else begin
          m_wait_cycles++;
          if (m_wait_cycles >= MAXW) m_err = 1;
        end
      end else if (m_frozen()) begin
        m_waiting = 1;
        m_wait_cycles = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_in();
    reset = 0; id_rs1 = 0; id_rs2 = 0; idex_rd = 0; idex_memread = 0;
    exmem_branch = 0; exmem_zero = 0; exmem_memread = 0; exmem_memwrite = 0;
    dmem_ready = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    clear_in();
    reset = 1; exmem_memread = 1; exmem_branch = 1; exmem_zero = 1;
    @(negedge clk);
    checks++;
    if (obs !== V_RESET) begin
      errors++; $display("FAIL reset_outputs got %b want %b", obs, V_RESET);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || mem_err !== 1'b0) begin
      errors++; $display("FAIL reset_state got stall=%0d flush=%0d err=%b want 0 0 0",
                         stall_cnt, flush_cnt, mem_err);
    end
    checks++;
    if (obs !== V_NORM) begin
      errors++; $display("FAIL post_reset_outputs got %b want %b", obs, V_NORM);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    idex_memread = 1; idex_rd = 5; id_rs2 = 5; id_rs1 = 3;
    @(negedge clk);
    checks++;
    if (obs !== V_LU) begin
      errors++; $display("FAIL load_use_outputs got %b want %b", obs, V_LU);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 8'd1) begin
      errors++; $display("FAIL load_use_stall_cnt got %0d want 1", stall_cnt);
    end
    checks++;
    if (obs !== V_NORM) begin
      errors++; $display("FAIL load_use_release got %b want %b", obs, V_NORM);
    end
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    idex_memread = 1; idex_rd = 0; id_rs1 = 0; id_rs2 = 7;
    @(negedge clk);
    checks++;
    if (obs !== V_NORM) begin
      errors++; $display("FAIL x0_no_stall got %b want %b", obs, V_NORM);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    exmem_branch = 1; exmem_zero = 1; idex_memread = 1; idex_rd = 9; id_rs1 = 9;
    @(negedge clk);
    checks++;
    if (obs !== V_BR) begin
      errors++; $display("FAIL branch_outputs got %b want %b", obs, V_BR);
    end
    tick();
    exmem_zero = 0; idex_memread = 0;
    @(negedge clk);
    checks++;
    if (flush_cnt !== 8'd1 || stall_cnt !== 8'd0) begin
      errors++; $display("FAIL branch_counters got flush=%0d stall=%0d want 1 0",
                         flush_cnt, stall_cnt);
    end
    checks++;
    if (obs !== V_NORM) begin
      errors++; $display("FAIL branch_not_taken got %b want %b", obs, V_NORM);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (flush_cnt !== 8'd1) begin
      errors++; $display("FAIL not_taken_flush_cnt got %0d want 1", flush_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    exmem_memread = 1; dmem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== V_FROZEN) begin
        errors++; $display("FAIL mem_wait_frozen cycle %0d got %b want %b", c, obs, V_FROZEN);
      end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== V_REL) begin
      errors++; $display("FAIL mem_wait_release got %b want %b", obs, V_REL);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 8'd3 || obs !== V_NORM) begin
      errors++; $display("FAIL mem_wait_after got stall=%0d vec=%b want 3 %b",
                         stall_cnt, obs, V_NORM);
    end
    // zero-wait access
    do_reset();
    exmem_memwrite = 1; dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== V_REL) begin
      errors++; $display("FAIL zero_wait_outputs got %b want %b", obs, V_REL);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 8'd0) begin
      errors++; $display("FAIL zero_wait_stall_cnt got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    exmem_memwrite = 1; dmem_ready = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checks++;
      if (mem_err !== (k >= 6)) begin
        errors++; $display("FAIL timeout_err cycle %0d got %b want %b", k, mem_err, k >= 6);
      end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    checks++;
    if (obs !== V_REL || mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_release got vec=%b err=%b want %b 1", obs, mem_err, V_REL);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b1 || stall_cnt !== 8'd6) begin
      errors++; $display("FAIL timeout_sticky got err=%b stall=%0d want 1 6", mem_err, stall_cnt);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_reset_clear got %b want 0", mem_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    exmem_memread = 1; dmem_ready = 0;
    tick();
    tick();
    reset = 1;
    @(negedge clk);
    checks++;
    if (obs !== V_RESET) begin
      errors++; $display("FAIL mid_wait_reset_outputs got %b want %b", obs, V_RESET);
    end
    tick();
    clear_in();
    @(negedge clk);
    checks++;
    if (obs !== V_NORM || stall_cnt !== 8'd0) begin
      errors++; $display("FAIL mid_wait_after_reset got vec=%b stall=%0d want %b 0",
                         obs, stall_cnt, V_NORM);
    end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] ev;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset          = ($urandom_range(63) == 0);
      id_rs1         = 5'($urandom_range(3));
      id_rs2         = 5'($urandom_range(3));
      idex_rd        = 5'($urandom_range(3));
      idex_memread   = 1'($urandom_range(1));
      exmem_branch   = ($urandom_range(3) == 0);
      exmem_zero     = 1'($urandom_range(1));
      exmem_memread  = ($urandom_range(7) == 0);
      exmem_memwrite = ($urandom_range(7) == 0);
      dmem_ready     = ($urandom_range(2) != 0);
      @(negedge clk);
      ev = exp_vec();
      checks++;
      if (obs !== ev) begin
        errors++; $display("FAIL rand_outputs cyc %0d got %b want %b", i, obs, ev);
      end
      checks++;
      if (stall_cnt !== CW'(m_stall)) begin
        errors++; $display("FAIL rand_stall_cnt cyc %0d got %0d want %0d", i, stall_cnt, m_stall);
      end
      checks++;
      if (flush_cnt !== CW'(m_flush)) begin
        errors++; $display("FAIL rand_flush_cnt cyc %0d got %0d want %0d", i, flush_cnt, m_flush);
      end
      checks++;
      if (mem_err !== m_err) begin
        errors++; $display("FAIL rand_mem_err cyc %0d got %b want %b", i, mem_err, m_err);
      end
      tick();
    end
  endtask

  initial begin
    clear_in();
    m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stall = 0; m_flush = 0;
    #1;
    test_reset();
    test_load_use();
    test_x0();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. It drives the enable and flush inputs of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers. It detects load-use hazards and taken branches resolved in MEM, and sequences multi-cycle data-memory accesses through a req/ready handshake. It also keeps stall and flush performance counters.

## Interface
- MEM_WAIT_MAX, 16, memory-wait cycles after which `mem_err` is raised
- CNT_W, 32, width of performance counters
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_rs1, id_rs2  in  5  source registers of instruction in ID
- idex_rd  in  5  destination register in ID_EX
- idex_memread  in  1  ID_EX instruction is a load
- exmem_branch, exmem_zero  in  1  branch control and ALU zero from EX_MEM
- exmem_memread, exmem_memwrite  in  1  EX_MEM memory access
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data-memory request
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage-register load enables
- ifid_flush, idex_flush, exmem_flush  out  1  stage-register clear (insert bubble)
- pc_sel  out  1  1 = PC loads branch target (addsum from EX_MEM)
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt, flush_cnt  out  CNT_W  performance counters

## Operation
- FSM states: RUN, MEM_WAIT. The reset state is RUN.
- Outputs are combinational from the state and the inputs. Defaults: all enables 1, flushes 0, `pc_sel` 0, `dmem_req` 0.
- Priority, highest first: memory wait, branch flush, load-use stall.
- **Memory access (RUN):** if `exmem_memread | exmem_memwrite`, then `dmem_req=1`.
  - If `dmem_ready=1` in the same cycle, there is no stall.
  - Otherwise all five enables are 0, flushes are 0, and the FSM goes to MEM_WAIT.
- **MEM_WAIT:**
  - `dmem_req=1` and all enables are 0.
  - When `dmem_ready=1`, enables are 1 and the FSM returns to RUN at the next edge.
  - Branch and load-use evaluation is suppressed in MEM_WAIT. A taken branch in EX_MEM is evaluated on the release cycle using the normal rules.
- **Branch taken** (`exmem_branch & exmem_zero`, not waiting):
  - Outputs: `pc_sel=1`, `ifid_flush=1`, `idex_flush=1`, `exmem_flush=1`, `pc_en=1`.
  - `flush_cnt` increments by 1.
  - Any coincident load-use condition is ignored.
- **Load-use:** condition is `idex_memread & (idex_rd != 0) & (idex_rd == id_rs1 | idex_rd == id_rs2)`.
  - Outputs: `pc_en=0`, `ifid_en=0`, `idex_flush=1`. The other enables stay 1.
  - Holds exactly one cycle, since the bubble clears `idex_memread`.
- **Counters:**
  - `stall_cnt` increments on every load-use cycle and every cycle with the enables frozen by a memory wait.
  - Both counters wrap modulo 2^CNT_W.
- **Timeout:**
  - The wait counter clears on entry to MEM_WAIT and saturates at MEM_WAIT_MAX.
  - When it reaches MEM_WAIT_MAX, `mem_err` is set and stays set until reset.
  - The FSM keeps waiting after a timeout.

## Timing
- **Reset asserted (that cycle):**
  - All enables 0, all flushes 1, `pc_sel=0`, `dmem_req=0`.
  - At the edge: state RUN, counters 0, `mem_err=0`, wait counter 0.
- **Reset mid-MEM_WAIT:** the FSM returns to RUN at the edge and `dmem_req` drops in the reset cycle.
- **Latency:** hazard and branch responses take zero cycles (same-cycle combinational). FSM transitions take one edge.
- **Counter timing:** counter updates are visible the cycle after the event.
- **Handshake:** `dmem_req` is held high continuously from the first request cycle until and including the `dmem_ready` cycle. `dmem_ready` without `dmem_req` is ignored.

## Structure
- Package `pipeline_ctrl_pkg`:
  - state enum `{RUN, MEM_WAIT}`
  - `REG_IDX_W=5`
  - constant `X0=5'd0`
- Sub-module `hazard_detect`: a pure combinational load-use compare with inputs `id_rs1`, `id_rs2`, `idex_rd`, `idex_memread` and output `load_use`.
- Top level holds the FSM, wait counter, performance counters and output muxing.

## Test plan
- **Load-use:** `idex_memread=1`, `idex_rd=5`, `id_rs2=5` → for one cycle `pc_en=0`, `ifid_en=0`, `idex_flush=1`; `stall_cnt` 0→1.
- **x0 exclusion:** `idex_rd=0`, `id_rs1=0`, `idex_memread=1` → no stall; all enables 1.
- **Branch taken with coincident load-use:**
  - `exmem_branch=1`, `exmem_zero=1`, plus a load-use hit → `pc_sel=1`, `ifid_flush`/`idex_flush`/`exmem_flush=1`, `pc_en=1`; `flush_cnt=1`; `stall_cnt` unchanged.
  - Same with `exmem_zero=0` → no flush.
- **Memory wait:**
  - `exmem_memread=1`, `dmem_ready` low for 3 cycles then high → 3 cycles with all enables 0 and `dmem_req=1`, then a release cycle with enables 1; `stall_cnt=3`.
  - Zero-wait case (`dmem_ready=1` immediately) → `stall_cnt=0`.
- **Timeout:** MEM_WAIT_MAX=4, `dmem_ready` held low for 6 cycles → `mem_err` rises after the 4th wait cycle and stays high after ready; reset clears it.
- **Reset mid-wait:** reset asserted on cycle 2 of MEM_WAIT → `dmem_req=0` and flushes 1 that cycle; next cycle state RUN and counters 0.
